// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl
// Wishbone-slave GPIO controller with WIDTH pins. Provides per-pin output
// enables, atomic set/clear/toggle of the output latch, a multi-flop input
// synchroniser, and per-pin rising/falling edge interrupts collected in a
// sticky write-1-to-clear status register.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   adr_i    byte address, only adr_i[5:2] selects a register
//   dat_i    write data
//   dat_o    registered read data, non-zero only while ack_o is high
//   we_i     write enable
//   sel_i    byte-lane select
//   stb_i    strobe
//   cyc_i    bus cycle
//   ack_o    single-cycle acknowledge, one cycle after the request
//   gpio_i   asynchronous pad inputs
//   gpio_o   pad output values (DATA_OUT register)
//   gpio_oe  pad output enables, 1 = drive (DIR register)
//   irq_o    level interrupt, high while any status bit is pending
//
// Register map (word offsets):
//   0x00 DATA_IN  RO    0x04 DATA_OUT RW    0x08 DIR     RW
//   0x0C OUT_SET  WO    0x10 OUT_CLR  WO    0x14 OUT_TGL WO
//   0x18 RISE_EN  RW    0x1C FALL_EN  RW    0x20 IRQ_STAT RW1C
//   0x24-0x3C read as zero, writes ignored, still acknowledged.

module wb_gpio_ctrl #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      adr_i,
   input  logic [31:0]      dat_i,
   output logic [31:0]      dat_o,
   input  logic             we_i,
   input  logic [3:0]       sel_i,
   input  logic             stb_i,
   input  logic             cyc_i,
   output logic             ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq_o
);

   localparam logic [3:0] REG_DATA_IN  = 4'h0;
   localparam logic [3:0] REG_DATA_OUT = 4'h1;
   localparam logic [3:0] REG_DIR      = 4'h2;
   localparam logic [3:0] REG_OUT_SET  = 4'h3;
   localparam logic [3:0] REG_OUT_CLR  = 4'h4;
   localparam logic [3:0] REG_OUT_TGL  = 4'h5;
   localparam logic [3:0] REG_RISE_EN  = 4'h6;
   localparam logic [3:0] REG_FALL_EN  = 4'h7;
   localparam logic [3:0] REG_IRQ_STAT = 4'h8;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_stat;
   logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] byte_mask;
   logic [WIDTH-1:0] wfield;
   logic [WIDTH-1:0] w1c_mask;
   logic [31:0]      lane_mask;
   logic [31:0]      wdata_m;
   logic [31:0]      rd_data;
   logic [3:0]       reg_sel;
   logic             req;
   logic             wr_req;
   logic             unused_bits;

   // A new request is only recognised while ack_o is low, so a held strobe
   // gets acknowledged every other cycle.
   assign req     = cyc_i & stb_i & ~ack_o;
   assign wr_req  = req & we_i;
   assign reg_sel = adr_i[5:2];

   // Byte-lane mask: plain RW registers merge only selected bytes, while the
   // set/clear/toggle/W1C registers use dat_i with unselected bytes zeroed.
   assign lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
   assign wdata_m   = dat_i & lane_mask;
   assign byte_mask = lane_mask[WIDTH-1:0];
   assign wfield    = wdata_m[WIDTH-1:0];

   assign sync = sync_ff[SYNC_STAGES-1];

   // Edge detection compares the synchronised pins with last cycle's value,
   // gated by the per-pin enables.
   assign rise     = sync & ~prev & rise_en;
   assign fall     = ~sync & prev & fall_en;
   assign w1c_mask = (wr_req && reg_sel == REG_IRQ_STAT) ? wfield : '0;

   assign gpio_o  = data_out;
   assign gpio_oe = dir;
   assign irq_o   = |irq_stat;

   // Address bits outside the decoded range and data bits above WIDTH are
   // deliberately ignored.
   assign unused_bits = &{1'b0, adr_i[31:6], adr_i[1:0], wdata_m};

   // Read multiplexer; write-only and unmapped offsets read as zero and the
   // bits above WIDTH are always zero.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_DATA_IN:  rd_data[WIDTH-1:0] = sync;
         REG_DATA_OUT: rd_data[WIDTH-1:0] = data_out;
         REG_DIR:      rd_data[WIDTH-1:0] = dir;
         REG_RISE_EN:  rd_data[WIDTH-1:0] = rise_en;
         REG_FALL_EN:  rd_data[WIDTH-1:0] = fall_en;
         REG_IRQ_STAT: rd_data[WIDTH-1:0] = irq_stat;
         default:      rd_data = '0;
      endcase
   end

   // Input synchroniser chain plus the previous-value register used for edge
   // detection; all cleared on reset so no edge is seen coming out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_ff[i] <= '0;
         end
         prev <= '0;
      end else begin
         sync_ff[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
         prev <= sync;
      end
   end

   // Bus handshake, register writes and interrupt status. A write lands on
   // the same edge that raises ack_o. Reset takes priority, so a request
   // coinciding with reset is dropped entirely. In the status update a new
   // edge is ORed in after the clear, so a simultaneous edge wins over W1C.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_o    <= 1'b0;
         dat_o    <= '0;
         data_out <= '0;
         dir      <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
         irq_stat <= '0;
      end else begin
         ack_o <= req;
         dat_o <= (req && !we_i) ? rd_data : '0;
         if (wr_req) begin
            case (reg_sel)
               REG_DATA_OUT: data_out <= (data_out & ~byte_mask) | wfield;
               REG_DIR:      dir      <= (dir & ~byte_mask) | wfield;
               REG_OUT_SET:  data_out <= data_out | wfield;
               REG_OUT_CLR:  data_out <= data_out & ~wfield;
               REG_OUT_TGL:  data_out <= data_out ^ wfield;
               REG_RISE_EN:  rise_en  <= (rise_en & ~byte_mask) | wfield;
               REG_FALL_EN:  fall_en  <= (fall_en & ~byte_mask) | wfield;
               default:      ;
            endcase
         end
         irq_stat <= (irq_stat & ~w1c_mask) | rise | fall;
      end
   end

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// tb_wb_gpio_ctrl
// Directed self-checking bench for wb_gpio_ctrl with WIDTH = 8 and
// SYNC_STAGES = 2. Inputs change on the falling edge, outputs are sampled
// 1 ns after the rising edge.

module tb_wb_gpio_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        we_i;
   logic [3:0]  sel_i;
   logic        stb_i;
   logic        cyc_i;
   logic        ack_o;
   logic [7:0]  gpio_i;
   logic [7:0]  gpio_o;
   logic [7:0]  gpio_oe;
   logic        irq_o;

   int total = 0;
   int bad   = 0;

   wb_gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .adr_i   (adr_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .we_i    (we_i),
      .sel_i   (sel_i),
      .stb_i   (stb_i),
      .cyc_i   (cyc_i),
      .ack_o   (ack_o),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .gpio_oe (gpio_oe),
      .irq_o   (irq_o)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts it and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One Wibhbone transfer: request on a falling edge, expect a one-cycle
   // ack after the next rising edge, then drop the strobe.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdat, input logic [3:0] sel,
                                output logic [31:0] rdat);
      @(negedge clk);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = wr;
      adr_i = addr;
      dat_i = wdat;
      sel_i = sel;
      @(posedge clk);
      #1;
      checkOutput("ack_rise", {31'b0, ack_o}, 32'd1);
      rdat = dat_o;
      if (wr) checkOutput("wr_dat_o_zero", dat_o, 32'h0);
      @(negedge clk);
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ack_fall", {31'b0, ack_o}, 32'd0);
   endtask

   logic [31:0] rd;
   int          ack_count;

   initial begin
      rst    = 1'b1;
      adr_i  = '0;
      dat_i  = '0;
      we_i   = 1'b0;
      sel_i  = 4'h0;
      stb_i  = 1'b0;
      cyc_i  = 1'b0;
      gpio_i = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ack",   {31'b0, ack_o}, 32'd0);
      checkOutput("rst_dat_o", dat_o, 32'h0);
      checkOutput("rst_gpio_o", {24'b0, gpio_o}, 32'h0);
      checkOutput("rst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
      checkOutput("rst_irq",   {31'b0, irq_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Direction and output data
      applyStimulus(1'b1, 32'h08, 32'h0000_00FF, 4'hF, rd);
      checkOutput("dir_oe", {24'b0, gpio_oe}, 32'hFF);
      applyStimulus(1'b1, 32'h04, 32'h0000_00A5, 4'hF, rd);
      checkOutput("dout_a5", {24'b0, gpio_o}, 32'hA5);
      applyStimulus(1'b0, 32'h04, 32'h0, 4'hF, rd);
      checkOutput("rd_dout", rd, 32'h0000_00A5);

      // Atomic set / clear / toggle
      applyStimulus(1'b1, 32'h0C, 32'h0A, 4'hF, rd);
      checkOutput("set_0a", {24'b0, gpio_o}, 32'hAF);
      applyStimulus(1'b1, 32'h10, 32'h81, 4'hF, rd);
      checkOutput("clr_81", {24'b0, gpio_o}, 32'h2E);
      applyStimulus(1'b1, 32'h14, 32'hFF, 4'hF, rd);
      checkOutput("tgl_ff", {24'b0, gpio_o}, 32'hD1);
      applyStimulus(1'b1, 32'h04, 32'h00, 4'h0, rd);
      checkOutput("sel0_noop", {24'b0, gpio_o}, 32'hD1);
      applyStimulus(1'b1, 32'h04, 32'hFFFF_FFFF, 4'hE, rd);
      checkOutput("sel_upper_noop", {24'b0, gpio_o}, 32'hD1);
      applyStimulus(1'b1, 32'h0C, 32'hFF, 4'h2, rd);
      checkOutput("set_masked", {24'b0, gpio_o}, 32'hD1);
      applyStimulus(1'b0, 32'h0C, 32'h0, 4'hF, rd);
      checkOutput("rd_wo_zero", rd, 32'h0);

      // Input synchroniser latency: early read sees old value
      @(negedge clk);
      gpio_i = 8'h3C;
      applyStimulus(1'b0, 32'h00, 32'h0, 4'hF, rd);
      checkOutput("din_early", rd, 32'h00);
      applyStimulus(1'b0, 32'h00, 32'h0, 4'hF, rd);
      checkOutput("din_3c", rd, 32'h3C);

      // Edge interrupts
      @(negedge clk);
      gpio_i = 8'h3E;
      repeat (4) @(negedge clk);
      applyStimulus(1'b1, 32'h18, 32'h01, 4'hF, rd);
      applyStimulus(1'b1, 32'h1C, 32'h02, 4'hF, rd);
      checkOutput("irq_idle", {31'b0, irq_o}, 32'd0);
      @(negedge clk);
      gpio_i = 8'h3D;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("irq_not_yet", {31'b0, irq_o}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("irq_set", {31'b0, irq_o}, 32'd1);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd);
      checkOutput("stat_03", rd, 32'h03);
      applyStimulus(1'b1, 32'h20, 32'h01, 4'hF, rd);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd);
      checkOutput("stat_02", rd, 32'h02);
      checkOutput("irq_still", {31'b0, irq_o}, 32'd1);
      applyStimulus(1'b1, 32'h20, 32'h02, 4'hF, rd);
      checkOutput("irq_clear", {31'b0, irq_o}, 32'd0);

      // W1C colliding with a new rising edge on bit 0: set wins
      @(negedge clk);
      gpio_i = 8'h3C;
      repeat (4) @(negedge clk);
      checkOutput("irq_quiet", {31'b0, irq_o}, 32'd0);
      gpio_i = 8'h3D;
      @(negedge clk);
      applyStimulus(1'b1, 32'h20, 32'h01, 4'hF, rd);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd);
      checkOutput("stat_collide", rd, 32'h01);

      // Clearing the enable leaves the pending bit alone
      applyStimulus(1'b1, 32'h18, 32'h00, 4'hF, rd);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd);
      checkOutput("stat_sticky", rd, 32'h01);
      applyStimulus(1'b1, 32'h20, 32'h01, 4'hF, rd);
      checkOutput("irq_final_clr", {31'b0, irq_o}, 32'd0);

      // Unmapped space
      applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, rd);
      checkOutput("rd_unmapped", rd, 32'h0);
      applyStimulus(1'b1, 32'h30, 32'hFF, 4'hF, rd);
      checkOutput("wr_unmapped", {24'b0, gpio_o}, 32'hD1);

      // Held strobe: acked every other cycle
      @(negedge clk);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b0;
      adr_i = 32'h04;
      ack_count = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (ack_o) ack_count++;
      end
      checkOutput("held_acks", ack_count, 32'd3);
      @(negedge clk);
      cyc_i = 1'b0;
      stb_i = 1'b0;
      @(posedge clk);
      #1;

      // Reset coinciding with a write request
      @(negedge clk);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b1;
      adr_i = 32'h04;
      dat_i = 32'h55;
      sel_i = 4'hF;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_mid_ack", {31'b0, ack_o}, 32'd0);
      checkOutput("rst_mid_gpio_o", {24'b0, gpio_o}, 32'h0);
      checkOutput("rst_mid_gpio_oe", {24'b0, gpio_oe}, 32'h0);
      @(negedge clk);
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      rst   = 1'b0;
      applyStimulus(1'b0, 32'h04, 32'h0, 4'hF, rd);
      checkOutput("rst_dout_rd", rd, 32'h0);
      applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
      checkOutput("rst_fall_en_rd", rd, 32'h0);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd);
      checkOutput("rst_stat_rd", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_gpio_ctrl.md
Name: wb_gpio_ctrl

Overview:
- Parametrised Wishbone-slave GPIO controller, successor to the 4-pin bit-addressed GPIO.
- Provides WIDTH pins with per-pin direction, atomic set/clear/toggle of outputs, input synchronisation, and per-pin rising/falling-edge interrupts with a sticky write-1-to-clear status register.
- Sits on the SoC Wishbone bus beside other peripherals; irq_o goes to the core interrupt controller.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, flip-flop stages on each input pin (2..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- adr_i  in  32  byte address; only adr_i[5:2] decoded
- dat_i  in  32  write data
- dat_o  out  32  read data
- we_i  in  1  write enable
- sel_i  in  4  byte-lane select
- stb_i  in  1  strobe
- cyc_i  in  1  bus cycle
- ack_o  out  1  acknowledge
- gpio_i  in  WIDTH  pad inputs (asynchronous)
- gpio_o  out  WIDTH  pad output values
- gpio_oe  out  WIDTH  pad output enables (1 = drive)
- irq_o  out  1  interrupt request, level

Behaviour:
- Register map (offset, access):
  - 0x00 DATA_IN, RO: synchronised pins.
  - 0x04 DATA_OUT, RW.
  - 0x08 DIR, RW: 1 = output.
  - 0x0C OUT_SET, WO: DATA_OUT |= wdata.
  - 0x10 OUT_CLR, WO: DATA_OUT &= ~wdata.
  - 0x14 OUT_TGL, WO: DATA_OUT ^= wdata.
  - 0x18 RISE_EN, RW.
  - 0x1C FALL_EN, RW.
  - 0x20 IRQ_STAT, RW1C.
  - WO registers read 0. Offsets 0x24-0x3C: reads return 0, writes are ignored, but still acked.
- Only bits [WIDTH-1:0] are stored. Upper read bits are 0.
- Byte lanes:
  - Writes apply only to bytes with sel_i set.
  - For SET/CLR/TGL/W1C, the effective wdata is dat_i masked by the sel_i lanes.
- Handshake:
  - A request is cyc_i & stb_i & ~ack_o.
  - ack_o asserts in the cycle after the request, for exactly one cycle.
  - A held strobe is therefore acked every other cycle.
  - Register write takes effect at the same edge that raises ack_o.
- Read data:
  - dat_o is registered and valid while ack_o = 1.
  - dat_o = 0 in all other cycles and for writes.
- Outputs: gpio_o = DATA_OUT and gpio_oe = DIR, both directly from registers with no extra latency.
- Input path:
  - Each pin passes SYNC_STAGES flops, giving sync.
  - DATA_IN = sync for every pin, regardless of DIR.
  - A pin change appears in DATA_IN SYNC_STAGES cycles later.
- Edge detection:
  - prev <= sync every cycle.
  - rise = sync & ~prev & RISE_EN.
  - fall = ~sync & prev & FALL_EN.
  - IRQ_STAT <= (IRQ_STAT & ~w1c_mask) | rise | fall.
  - If a W1C and a new edge hit the same bit in the same cycle, set wins.
  - Pin edge to IRQ_STAT set takes SYNC_STAGES+1 cycles.
  - Clearing an enable does not clear its pending status bit.
- irq_o = |IRQ_STAT, combinational from the register.
- Reset:
  - ack_o = 0, dat_o = 0.
  - DATA_OUT, DIR, RISE_EN, FALL_EN, IRQ_STAT = 0.
  - Synchroniser and prev = 0.
  - Consequences: gpio_o = 0, gpio_oe = 0, irq_o = 0.
  - Because enables reset to 0, no spurious status is set after reset.
  - Reset asserted mid-transaction drops any pending ack. The aborted write has no effect if rst and request coincide at the edge.

Test Plan:
- Reset, then write DIR = 0xFF and DATA_OUT = 0xA5 (sel_i = 0xF) -> gpio_oe = 0xFF and gpio_o = 0xA5. Each ack_o is a 1-cycle pulse one cycle after stb; readback of 0x04 gives 0x000000A5.
- From DATA_OUT = 0xA5: write OUT_SET 0x0A -> 0xAF; OUT_CLR 0x81 -> 0x2E; OUT_TGL 0xFF -> 0xD1. A write with sel_i = 0x0 changes nothing but is still acked.
- Drive gpio_i = 0x3C -> read of DATA_IN returns 0x3C once SYNC_STAGES cycles have passed, and returns the old value if read earlier.
- RISE_EN = 0x01, FALL_EN = 0x02; pulse gpio_i[0] 0->1 and gpio_i[1] 1->0 -> IRQ_STAT = 0x03 and irq_o = 1 at SYNC_STAGES+1 cycles. Write 0x01 to 0x20 -> IRQ_STAT = 0x02 and irq_o stays 1; write 0x02 -> irq_o = 0.
- W1C of bit 0 issued in the same cycle a new rising edge reaches detection -> bit 0 remains set.
- Read unmapped 0x30 -> ack with dat_o = 0. Holding stb_i for 6 cycles -> exactly 3 ack pulses. Asserting rst during a pending ack -> ack_o = 0 next cycle and all registers are at reset values.
